// File: rtl/riscv_str_if.sv
// Request/result bundle between the EX stage and the string unit.
// The EX side is the master; the string unit is the slave.
interface riscv_str_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int STR_OP_WIDTH = 3
);
   logic                    enable_i;
   logic [STR_OP_WIDTH-1:0] operator_i;
   logic [DATA_WIDTH-1:0]   operand_a_i;
   logic [DATA_WIDTH-1:0]   operand_b_i;
   logic                    flush_i;
   logic                    ex_ready_i;
   logic                    ready_o;
   logic                    valid_o;
   logic [DATA_WIDTH-1:0]   result_o;

   modport master (
      output enable_i, operator_i, operand_a_i, operand_b_i, flush_i, ex_ready_i,
      input  ready_o, valid_o, result_o
   );

   modport slave (
      input  enable_i, operator_i, operand_a_i, operand_b_i, flush_i, ex_ready_i,
      output ready_o, valid_o, result_o
   );
endinterface

// File: rtl/riscv_str_unit.sv
// Iterative byte-lane string unit: case maps, leet, rot13/caesar, letter count and NUL search,
// processing LANES bytes per cycle with C-string early termination and a held result.
module riscv_str_unit #(
   parameter int DATA_WIDTH   = 32,
   parameter int LANES        = 1,
   parameter int STR_OP_WIDTH = 3
) (
   input logic        clk,
   input logic        rst_n,
   riscv_str_if.slave bus
);
   localparam int NBYTES  = DATA_WIDTH / 8;
   localparam int NGROUPS = NBYTES / LANES;
   localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
   localparam int CW      = $clog2(NBYTES + 1);
   localparam int SW      = $clog2(DATA_WIDTH);
   localparam int LW      = LANES * 8;

   localparam logic [STR_OP_WIDTH-1:0] OP_UPPER  = STR_OP_WIDTH'(0);
   localparam logic [STR_OP_WIDTH-1:0] OP_LOWER  = STR_OP_WIDTH'(1);
   localparam logic [STR_OP_WIDTH-1:0] OP_LEET   = STR_OP_WIDTH'(2);
   localparam logic [STR_OP_WIDTH-1:0] OP_ROT13  = STR_OP_WIDTH'(3);
   localparam logic [STR_OP_WIDTH-1:0] OP_CAESAR = STR_OP_WIDTH'(4);
   localparam logic [STR_OP_WIDTH-1:0] OP_TOGGLE = STR_OP_WIDTH'(5);
   localparam logic [STR_OP_WIDTH-1:0] OP_COUNT  = STR_OP_WIDTH'(6);
   localparam logic [STR_OP_WIDTH-1:0] OP_FINDZ  = STR_OP_WIDTH'(7);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                  state_reg, state_next;
   logic [GW-1:0]           group_reg, group_next;
   logic [STR_OP_WIDTH-1:0] op_reg, op_next;
   logic [4:0]              shift_reg, shift_next;
   logic [DATA_WIDTH-1:0]   data_reg, data_next;
   logic [DATA_WIDTH-1:0]   result_reg, result_next;
   logic [CW-1:0]           count_reg, count_next;

   logic [SW-1:0]         bit_base;
   logic [DATA_WIDTH-1:0] group_data;
   logic [7:0]            lane_in  [LANES];
   logic [7:0]            lane_out [LANES];
   logic [LANES-1:0]      lane_nul, lane_alpha, lane_act;
   logic [LW-1:0]         lane_vec, lane_mask;
   logic                  any_nul;
   logic [DATA_WIDTH-1:0] first_nul;
   logic [CW-1:0]         group_count;
   logic                  last_group;

   // Rotate a letter within its own case; caller guarantees c is a letter and s < 26.
   function automatic logic [7:0] rotate(input logic [7:0] c, input logic [4:0] s);
      logic [7:0] base;
      logic [7:0] idx;
      base = (c >= 8'h61) ? 8'h61 : 8'h41;
      idx  = c - base + {3'b000, s};
      if (idx >= 8'd26) idx = idx - 8'd26;
      return base + idx;
   endfunction

   function automatic logic [7:0] xform(input logic [STR_OP_WIDTH-1:0] op,
                                        input logic [4:0] s, input logic [7:0] c);
      logic       is_up;
      logic       is_lo;
      logic [7:0] r;
      is_up = (c >= 8'h41) && (c <= 8'h5A);
      is_lo = (c >= 8'h61) && (c <= 8'h7A);
      r     = c;
      case (op)
         OP_UPPER:  if (is_lo) r = c - 8'h20;
         OP_LOWER:  if (is_up) r = c + 8'h20;
         OP_LEET: begin
            if (is_up || is_lo) begin
               case (c | 8'h20)
                  8'h61:   r = 8'h34;
                  8'h65:   r = 8'h33;
                  8'h69:   r = 8'h31;
                  8'h6F:   r = 8'h30;
                  8'h73:   r = 8'h35;
                  8'h74:   r = 8'h37;
                  default: r = c;
               endcase
            end
         end
         OP_ROT13:  if (is_up || is_lo) r = rotate(c, 5'd13);
         OP_CAESAR: if (is_up || is_lo) r = rotate(c, s);
         OP_TOGGLE: if (is_up || is_lo) r = c ^ 8'h20;
         default:   r = c;
      endcase
      return r;
   endfunction

   // The current group is shifted down to bit 0 so every lane uses a constant slice.
   assign bit_base   = SW'(group_reg) * SW'(LW);
   assign group_data = data_reg >> bit_base;
   assign last_group = (group_reg == GW'(NGROUPS - 1));

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_in[gi]          = group_data[gi*8 +: 8];
         assign lane_out[gi]         = xform(op_reg, shift_reg, lane_in[gi]);
         assign lane_nul[gi]         = (lane_in[gi] == 8'h00);
         assign lane_alpha[gi]       = ((lane_in[gi] | 8'h20) >= 8'h61) && ((lane_in[gi] | 8'h20) <= 8'h7A);
         assign lane_vec[gi*8 +: 8]  = lane_out[gi];
         assign lane_mask[gi*8 +: 8] = {8{lane_act[gi]}};
      end
   endgenerate

   // A lane is live only while no NUL has been seen at or below it in this group.
   always_comb begin
      any_nul     = 1'b0;
      first_nul   = '0;
      group_count = '0;
      lane_act    = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_act[i] = !any_nul && !lane_nul[i];
         if (lane_act[i] && lane_alpha[i]) group_count = group_count + CW'(1);
         if (lane_nul[i] && !any_nul) first_nul = DATA_WIDTH'(i);
         any_nul = any_nul | lane_nul[i];
      end
   end

   always_comb begin
      state_next  = state_reg;
      group_next  = group_reg;
      op_next     = op_reg;
      shift_next  = shift_reg;
      data_next   = data_reg;
      result_next = result_reg;
      count_next  = count_reg;
      if (bus.flush_i) begin
         state_next = S_IDLE;
         group_next = '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (bus.enable_i) begin
                  op_next     = bus.operator_i;
                  shift_next  = (bus.operand_b_i[4:0] >= 5'd26) ? bus.operand_b_i[4:0] - 5'd26
                                                                : bus.operand_b_i[4:0];
                  data_next   = bus.operand_a_i;
                  result_next = (bus.operator_i == OP_COUNT || bus.operator_i == OP_FINDZ)
                                ? '0 : bus.operand_a_i;
                  count_next  = '0;
                  group_next  = '0;
                  state_next  = S_BUSY;
               end
            end
            S_BUSY: begin
               if (op_reg == OP_COUNT) begin
                  count_next  = count_reg + group_count;
                  result_next = DATA_WIDTH'(count_next);
               end else if (op_reg == OP_FINDZ) begin
                  if (any_nul)
                     result_next = DATA_WIDTH'(group_reg) * DATA_WIDTH'(LANES) + first_nul;
                  else if (last_group)
                     result_next = DATA_WIDTH'(NBYTES);
               end else begin
                  result_next = (result_reg & ~(DATA_WIDTH'(lane_mask) << bit_base))
                              | (DATA_WIDTH'(lane_vec & lane_mask) << bit_base);
               end
               if (any_nul || last_group) state_next = S_DONE;
               else                       group_next = group_reg + GW'(1);
            end
            S_DONE: begin
               if (bus.ex_ready_i) begin
                  state_next = S_IDLE;
                  group_next = '0;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         group_reg  <= '0;
         op_reg     <= '0;
         shift_reg  <= '0;
         data_reg   <= '0;
         result_reg <= '0;
         count_reg  <= '0;
      end else begin
         group_reg  <= group_next;
         op_reg     <= op_next;
         shift_reg  <= shift_next;
         data_reg   <= data_next;
         result_reg <= result_next;
         count_reg  <= count_next;
      end
   end

   assign bus.ready_o  = (state_reg == S_IDLE);
   assign bus.valid_o  = (state_reg == S_DONE);
   assign bus.result_o = result_reg;
endmodule

// File: tb/tb_riscv_str_unit.sv
// Bench for riscv_str_unit: three instances (LANES 1, 2, 4) share stimulus and are checked
// against a character-level reference model for results and completion latency.
module tb_riscv_str_unit;
   localparam int DW = 32;
   localparam int NB = 4;
   localparam int NU = 3;

   localparam logic [2:0] UPPER  = 3'd0;
   localparam logic [2:0] LOWER  = 3'd1;
   localparam logic [2:0] LEET   = 3'd2;
   localparam logic [2:0] ROT13  = 3'd3;
   localparam logic [2:0] CAESAR = 3'd4;
   localparam logic [2:0] TOGGLE = 3'd5;
   localparam logic [2:0] COUNT  = 3'd6;
   localparam logic [2:0] FINDZ  = 3'd7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        flush;
   logic        ex_ready;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        ready  [NU];
   logic        valid  [NU];
   logic [31:0] result [NU];
   int          lanes_of [NU] = '{1, 2, 4};
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NU; gi++) begin : g_dut
      localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
      riscv_str_if #(.DATA_WIDTH(DW), .STR_OP_WIDTH(3)) bus ();
      assign bus.enable_i    = enable;
      assign bus.operator_i  = op;
      assign bus.operand_a_i = a;
      assign bus.operand_b_i = b;
      assign bus.flush_i     = flush;
      assign bus.ex_ready_i  = ex_ready;
      assign ready[gi]       = bus.ready_o;
      assign valid[gi]       = bus.valid_o;
      assign result[gi]      = bus.result_o;
      riscv_str_unit #(.DATA_WIDTH(DW), .LANES(L), .STR_OP_WIDTH(3)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   // Character-by-character reference: walk the C string until NUL.
   function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] av,
                                             input logic [31:0] bv);
      int sh, cnt, c, nc;
      bit up, lo;
      logic [31:0] r;
      sh  = int'(bv[4:0]) % 26;
      r   = av;
      cnt = 0;
      for (int k = 0; k < NB; k++) begin
         c = int'((av >> (8 * k)) & 32'hFF);
         if (c == 0) begin
            if (o == FINDZ) return 32'(k);
            if (o == COUNT) return 32'(cnt);
            return r;
         end
         up = (c >= 65 && c <= 90);
         lo = (c >= 97 && c <= 122);
         nc = c;
         case (o)
            UPPER:  if (lo) nc = c - 32;
            LOWER:  if (up) nc = c + 32;
            LEET: begin
               if (up || lo) begin
                  case (lo ? c : c + 32)
                     97:  nc = 52;
                     101: nc = 51;
                     105: nc = 49;
                     111: nc = 48;
                     115: nc = 53;
                     116: nc = 55;
                     default: nc = c;
                  endcase
               end
            end
            ROT13: begin
               if (up) nc = 65 + (c - 65 + 13) % 26;
               else if (lo) nc = 97 + (c - 97 + 13) % 26;
            end
            CAESAR: begin
               if (up) nc = 65 + (c - 65 + sh) % 26;
               else if (lo) nc = 97 + (c - 97 + sh) % 26;
            end
            TOGGLE: begin
               if (up) nc = c + 32;
               else if (lo) nc = c - 32;
            end
            COUNT: if (up || lo) cnt++;
            default: nc = c;
         endcase
         if (o != COUNT && o != FINDZ)
            r = (r & ~(32'hFF << (8 * k))) | (32'(nc) << (8 * k));
      end
      if (o == FINDZ) return 32'(NB);
      if (o == COUNT) return 32'(cnt);
      return r;
   endfunction

   function automatic int model_lat(input logic [31:0] av, input int lanes);
      for (int k = 0; k < NB; k++)
         if (((av >> (8 * k)) & 32'hFF) == 0) return k / lanes + 1;
      return NB / lanes;
   endfunction

   function automatic logic [7:0] rand_byte();
      case ($urandom_range(0, 7))
         0:       return 8'h00;
         1, 2:    return 8'(8'h41 + $urandom_range(0, 25));
         3, 4:    return 8'(8'h61 + $urandom_range(0, 25));
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_all_ready();
      int c = 0;
      while (!(ready[0] && ready[1] && ready[2]) && c < 20) begin
         tick();
         c++;
      end
      if (!(ready[0] && ready[1] && ready[2])) begin
         n_checks++;
         $display("FAIL wait_ready: ready=%b%b%b required 111", ready[0], ready[1], ready[2]);
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_r, input string tag);
      int          lat [NU];
      logic [31:0] got [NU];
      wait_all_ready();
      ex_ready = 1'b1;
      op = o; a = av; b = bv; enable = 1'b1;
      tick();
      enable = 1'b0;
      for (int u = 0; u < NU; u++) begin
         lat[u] = -1;
         got[u] = 'x;
      end
      for (int c = 1; c <= 8; c++) begin
         tick();
         for (int u = 0; u < NU; u++)
            if (valid[u] && lat[u] < 0) begin
               lat[u] = c;
               got[u] = result[u];
            end
      end
      for (int u = 0; u < NU; u++) begin
         n_checks++;
         if (got[u] !== exp_r)
            $display("FAIL %s_result lanes=%0d: got %h required %h", tag, lanes_of[u], got[u], exp_r);
         else n_pass++;
         n_checks++;
         if (lat[u] != model_lat(av, lanes_of[u]))
            $display("FAIL %s_latency lanes=%0d: got %0d required %0d", tag, lanes_of[u], lat[u],
                     model_lat(av, lanes_of[u]));
         else n_pass++;
      end
      $display("txn %s op=%0d a=%h b=%h exp=%h got=%h/%h/%h lat=%0d/%0d/%0d", tag, o, av, bv, exp_r,
               got[0], got[1], got[2], lat[0], lat[1], lat[2]);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; flush = 1'b0; ex_ready = 1'b1;
      op = '0; a = '0; b = '0;
      tick();
      tick();
      for (int u = 0; u < NU; u++) begin
         n_checks++;
         if (ready[u] !== 1'b1 || valid[u] !== 1'b0 || result[u] !== 32'h0)
            $display("FAIL reset lanes=%0d: ready=%b valid=%b result=%h required 1/0/00000000",
                     lanes_of[u], ready[u], valid[u], result[u]);
         else n_pass++;
      end
      #3 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      run_op(UPPER,  32'h64636261, 32'd0,  32'h44434241, "upper");
      run_op(UPPER,  32'h61006263, 32'd0,  32'h61004243, "upper_nul");
      run_op(ROT13,  32'h6E6F4841, 32'd0,  32'h6162554E, "rot13");
      run_op(CAESAR, 32'h41425A78, 32'd29, 32'h44454361, "caesar");
      run_op(LEET,   32'h74736574, 32'd0,  32'h37353337, "leet");
      run_op(FINDZ,  32'h11002233, 32'd0,  32'd2,        "findz_nul");
      run_op(FINDZ,  32'h11223344, 32'd0,  32'd4,        "findz_none");
      run_op(COUNT,  32'h317A4120, 32'd0,  32'd2,        "count");
      run_op(FINDZ,  32'h11223300, 32'd0,  32'd0,        "findz_first");
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] av, bv;
      for (int i = 0; i < 40; i++) begin
         o  = 3'($urandom_range(0, 7));
         av = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
         bv = $urandom;
         run_op(o, av, bv, model_res(o, av, bv), "rand");
      end
   endtask

   task automatic test_backpressure();
      int c = 0;
      wait_all_ready();
      ex_ready = 1'b0;
      op = UPPER; a = 32'h64636261; b = '0; enable = 1'b1;
      tick();
      enable = 1'b0;
      while (!valid[0] && c < 10) begin
         tick();
         c++;
      end
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (result[0] !== 32'h44434241 || valid[0] !== 1'b1 || ready[0] !== 1'b0)
            $display("FAIL hold cycle %0d: result=%h valid=%b ready=%b required 44434241/1/0",
                     i, result[0], valid[0], ready[0]);
         else n_pass++;
         if (i < 5) tick();
      end
      ex_ready = 1'b1;
      tick();
      n_checks++;
      if (ready[0] !== 1'b1 || valid[0] !== 1'b0)
         $display("FAIL release: ready=%b valid=%b required 1/0", ready[0], valid[0]);
      else n_pass++;
      op = LOWER; a = 32'h44434241; enable = 1'b1;
      tick();
      enable = 1'b0;
      n_checks++;
      if (ready[0] !== 1'b0)
         $display("FAIL accept_after_release: ready=%b required 0", ready[0]);
      else n_pass++;
      c = 0;
      while (!valid[0] && c < 10) begin
         tick();
         c++;
      end
      n_checks++;
      if (valid[0] !== 1'b1 || result[0] !== 32'h64636261)
         $display("FAIL second_op: valid=%b result=%h required 1/64636261", valid[0], result[0]);
      else n_pass++;
      $display("txn backpressure done");
   endtask

   task automatic test_back_to_back();
      logic [31:0] expq[$];
      logic [31:0] exp_r;
      int idx = 0, done = 0, idle_cnt = 0;
      bit accepted = 1'b0;
      wait_all_ready();
      ex_ready = 1'b1;
      op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      enable = 1'b1;
      for (int c = 0; c < 80 && done < 4; c++) begin
         if (ready[0] && enable) begin
            expq.push_back(model_res(op, a, b));
            accepted = 1'b1;
         end
         if (ready[0]) idle_cnt++;
         if (valid[0]) begin
            exp_r = (expq.size() > 0) ? expq.pop_front() : 32'hxxxxxxxx;
            n_checks++;
            if (result[0] !== exp_r)
               $display("FAIL b2b_result %0d: got %h required %h", done, result[0], exp_r);
            else n_pass++;
            if (done > 0) begin
               n_checks++;
               if (idle_cnt != 1)
                  $display("FAIL b2b_idle %0d: idle cycles %0d required 1", done, idle_cnt);
               else n_pass++;
            end
            $display("txn b2b %0d result=%h", done, result[0]);
            idle_cnt = 0;
            done++;
         end
         tick();
         if (accepted) begin
            accepted = 1'b0;
            idx++;
            if (idx < 4) begin
               op = 3'($urandom_range(0, 7));
               a  = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
               b  = $urandom;
            end else enable = 1'b0;
         end
      end
      enable = 1'b0;
      if (done < 4) begin
         n_checks++;
         $display("FAIL b2b_timeout: completed %0d required 4", done);
      end
   endtask

   task automatic test_flush();
      bit seen;
      int c = 0;
      // Flush in the second BUSY cycle.
      wait_all_ready();
      ex_ready = 1'b1;
      op = UPPER; a = 32'h64636261; b = '0; enable = 1'b1;
      tick();
      enable = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_checks++;
      if (ready[0] !== 1'b1 || valid[0] !== 1'b0)
         $display("FAIL flush_busy: ready=%b valid=%b required 1/0", ready[0], valid[0]);
      else n_pass++;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen |= valid[0];
      end
      n_checks++;
      if (seen) $display("FAIL flush_busy_valid: valid seen=1 required 0");
      else n_pass++;
      // Flush in IDLE drops a same-cycle enable.
      wait_all_ready();
      enable = 1'b1; flush = 1'b1;
      tick();
      enable = 1'b0; flush = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         seen |= valid[0] | valid[1] | valid[2] | !ready[0];
         tick();
      end
      n_checks++;
      if (seen) $display("FAIL flush_idle: request taken=1 required 0");
      else n_pass++;
      // Flush in DONE while the consumer stalls.
      ex_ready = 1'b0;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      while (!valid[0] && c < 10) begin
         tick();
         c++;
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_checks++;
      if (valid[0] !== 1'b0 || ready[0] !== 1'b1)
         $display("FAIL flush_done: valid=%b ready=%b required 0/1", valid[0], ready[0]);
      else n_pass++;
      ex_ready = 1'b1;
      $display("txn flush done");
   endtask

   task automatic test_async_reset();
      wait_all_ready();
      ex_ready = 1'b1;
      op = UPPER; a = 32'h64636261; b = '0; enable = 1'b1;
      tick();
      enable = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      for (int u = 0; u < NU; u++) begin
         n_checks++;
         if (ready[u] !== 1'b1 || valid[u] !== 1'b0 || result[u] !== 32'h0)
            $display("FAIL async_reset lanes=%0d: ready=%b valid=%b result=%h required 1/0/00000000",
                     lanes_of[u], ready[u], valid[u], result[u]);
         else n_pass++;
      end
      #1 rst_n = 1'b1;
      tick();
      $display("txn async_reset done");
      run_op(TOGGLE, 32'h7A5A6141, 32'd0, 32'h5A7A4161, "after_reset");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
